// File: rtl/audio_level_meter_pkg.sv
// Shared widths, types and the log2 bar-level helper for the stereo audio level meter.
package audio_meter_pkg;

    localparam int SAMPLE_W     = 16;
    localparam int LEVEL_W      = $clog2(SAMPLE_W);
    localparam int HOLD_WINDOWS = 8;
    localparam int HOLD_TMR_W   = $clog2(HOLD_WINDOWS + 1);

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic [SAMPLE_W-1:0]        mag_t;
    typedef logic [LEVEL_W-1:0]         level_t;

    // Bit length of the magnitude, capped so it fits the bar range.
    function automatic level_t msb_level(input mag_t magnitude);
        level_t lvl;
        lvl = '0;
        for (int i = 0; i < SAMPLE_W; i++) begin
            if (magnitude[i]) begin
                lvl = (i + 1 > SAMPLE_W - 1) ? level_t'(SAMPLE_W - 1) : level_t'(i + 1);
            end
        end
        return lvl;
    endfunction

endpackage

// File: rtl/audio_level_meter_if.sv
// Sample input and level output bundle between the I2S receiver, the meter and the bar renderer.
interface audio_level_meter_if;
    import audio_meter_pkg::*;

    logic    sample_valid;
    sample_t left_in;
    sample_t right_in;
    level_t  level_left;
    level_t  level_right;
    logic    level_valid;
    logic    clip_left;
    logic    clip_right;
    level_t  hold_left;
    level_t  hold_right;

    modport master (
        output sample_valid, left_in, right_in,
        input  level_left, level_right, level_valid,
        input  clip_left, clip_right, hold_left, hold_right
    );

    modport slave (
        input  sample_valid, left_in, right_in,
        output level_left, level_right, level_valid,
        output clip_left, clip_right, hold_left, hold_right
    );

endinterface

// File: rtl/audio_level_meter_channel.sv
// One meter channel: abs, window peak/clip, log2 conversion, decay and optional peak hold.
// Peak hold is built only when AUDIO_METER_PEAK_HOLD_EN is defined; otherwise hold is 0.
module meter_channel
    import audio_meter_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    sample_valid,
    input  sample_t sample_in,
    input  logic    acc_valid,
    input  logic    acc_first,
    input  logic    win_done,
    input  logic    raw_done,
    output level_t  level,
    output logic    clip,
    output level_t  hold
);

    localparam sample_t MAX_POS = sample_t'({1'b0, {(SAMPLE_W-1){1'b1}}});
    localparam sample_t MIN_NEG = sample_t'({1'b1, {(SAMPLE_W-1){1'b0}}});

    mag_t   abs_c;
    logic   hit_c;
    mag_t   abs_r;
    logic   hit_r;
    mag_t   peak;
    logic   clip_acc;
    level_t raw_r;
    logic   clip_win;
    level_t level_next;

    // Most negative input has no positive twin; saturate it.
    always_comb begin
        abs_c = mag_t'(sample_in);
        if (sample_in == MIN_NEG) begin
            abs_c = mag_t'(MAX_POS);
        end else if (sample_in[SAMPLE_W-1]) begin
            abs_c = mag_t'(-sample_in);
        end
        hit_c = (sample_in == MAX_POS) || (sample_in == MIN_NEG);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            abs_r <= '0;
            hit_r <= 1'b0;
        end else if (sample_valid) begin
            abs_r <= abs_c;
            hit_r <= hit_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            peak     <= '0;
            clip_acc <= 1'b0;
        end else if (acc_valid) begin
            if (acc_first) begin
                peak     <= abs_r;
                clip_acc <= hit_r;
            end else begin
                peak     <= (abs_r > peak) ? abs_r : peak;
                clip_acc <= clip_acc | hit_r;
            end
        end
    end

    // A back-to-back window may reload peak on this same edge; the old value is captured here.
    always_ff @(posedge clk) begin
        if (rst) begin
            raw_r    <= '0;
            clip_win <= 1'b0;
        end else if (win_done) begin
            raw_r    <= msb_level(peak);
            clip_win <= clip_acc;
        end
    end

    always_comb begin
        level_next = level;
        if (raw_r >= level) begin
            level_next = raw_r;
        end else begin
            level_next = level - level_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level <= '0;
            clip  <= 1'b0;
        end else if (raw_done) begin
            level <= level_next;
            clip  <= clip_win;
        end
    end

`ifdef AUDIO_METER_PEAK_HOLD_EN
    logic [HOLD_TMR_W-1:0] hold_tmr;

    // Timer counts the windows still to hold after the last rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold     <= '0;
            hold_tmr <= '0;
        end else if (raw_done) begin
            if (level_next >= hold) begin
                hold     <= level_next;
                hold_tmr <= HOLD_TMR_W'(HOLD_WINDOWS);
            end else if (hold_tmr == '0) begin
                hold <= level_next;
            end else begin
                hold_tmr <= hold_tmr - HOLD_TMR_W'(1);
            end
        end
    end
`else
    assign hold = '0;
`endif

endmodule

// File: rtl/audio_level_meter.sv
// Stereo audio level meter top: shared window counter, pipeline valids and two channel instances.
// Optional peak hold is enabled with AUDIO_METER_PEAK_HOLD_EN.
module audio_level_meter
    import audio_meter_pkg::*;
#(
    parameter int WINDOW = 256
)
(
    input  logic clk,
    input  logic rst,
    audio_level_meter_if.slave bus
);

    localparam int CNT_W = $clog2(WINDOW);

    logic [CNT_W-1:0] win_cnt;
    logic             acc_valid;
    logic             acc_first;
    logic             acc_last;
    logic             win_done;
    logic             raw_done;
    logic             level_valid_r;

    assign acc_first = (win_cnt == '0);
    assign acc_last  = (win_cnt == CNT_W'(WINDOW - 1));

    // acc_valid -> win_done -> raw_done -> level_valid, one edge each.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_valid     <= 1'b0;
            win_done      <= 1'b0;
            raw_done      <= 1'b0;
            level_valid_r <= 1'b0;
            win_cnt       <= '0;
        end else begin
            acc_valid     <= bus.sample_valid;
            win_done      <= acc_valid && acc_last;
            raw_done      <= win_done;
            level_valid_r <= raw_done;
            if (acc_valid) begin
                win_cnt <= acc_last ? '0 : win_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.level_valid = level_valid_r;

    meter_channel u_left (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (bus.sample_valid),
        .sample_in    (bus.left_in),
        .acc_valid    (acc_valid),
        .acc_first    (acc_first),
        .win_done     (win_done),
        .raw_done     (raw_done),
        .level        (bus.level_left),
        .clip         (bus.clip_left),
        .hold         (bus.hold_left)
    );

    meter_channel u_right (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (bus.sample_valid),
        .sample_in    (bus.right_in),
        .acc_valid    (acc_valid),
        .acc_first    (acc_first),
        .win_done     (win_done),
        .raw_done     (raw_done),
        .level        (bus.level_right),
        .clip         (bus.clip_right),
        .hold         (bus.hold_right)
    );

endmodule
